uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Accepts a byte from the winning requester, drives the transmitter's uart_en/data pair, and times the frame. The transmitter has no busy output, so the frame time is counted locally.
- Enforces a configurable idle gap between frames before the next grant.
- Sits directly upstream of the UART transmitter and its 115200-baud, 8N1 MSB-first frame.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate.
- BPS_CNT, CLK_FREQ/BAUD (434): clocks per bit, integer division.
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of grant_id, equal to clog2(NUM_REQ).
- EN_HOLD, 3: cycles uart_en is held high. Must be at least 3 so the transmitter's 2-stage edge detector sees the edge.
- GAP_BITS, 1: extra idle bit-times inserted after each frame.

Ports:
- clk  in  1: system clock, all logic on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- req  in  NUM_REQ: per-requester byte-valid. Held high, with its data stable, until ack.
- req_data  in  8*NUM_REQ: byte i occupies bits [8i+7:8i].
- ack  out  NUM_REQ: one-cycle pulse when byte i is captured.
- uart_en  out  1: start pulse to the transmitter.
- uart_data  out  8: byte to the transmitter. Stable from capture until the next capture.
- busy  out  1: high in any state other than IDLE.
- grant_id  out  ID_W: index of the last granted requester.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, ack=0, uart_en=0, uart_data=0, busy=0, grant_id=0, rr_ptr=NUM_REQ-1, frame counter=0. Reset mid-frame abandons the frame. uart_en drops at once; the transmitter finishes or resets on its own reset.
- FRAME_CYC = 10*BPS_CNT + EN_HOLD, i.e. start + 8 data + stop, plus the transmitter's edge-detect latency.
- GAP_CYC = GAP_BITS*BPS_CNT.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit searching upward from rr_ptr+1, modulo NUM_REQ.
  - Same cycle, registered: uart_data<=req_data[winner], ack[winner]<=1, grant_id<=winner, rr_ptr<=winner, cnt<=0, goto SEND.
  - req=0: remain in IDLE, all outputs hold.
- SEND:
  - ack deasserts after exactly 1 cycle.
  - uart_en=1 while cnt<EN_HOLD, i.e. uart_en rises the cycle after ack rises.
  - cnt increments each cycle. At cnt==FRAME_CYC-1: cnt<=0; goto GAP if GAP_CYC>0, else IDLE.
- GAP: count to GAP_CYC-1, then go to IDLE. No grant is issued during SEND or GAP.
- Latency: ack appears 1 cycle after req is seen in IDLE.
- Back-to-back requests: consecutive acks are FRAME_CYC+GAP_CYC+1 cycles apart (IDLE costs 1 cycle).
- Requester rules:
  - req may drop without an ack; the request is then withdrawn and is never sent.
  - A requester that keeps req high after its ack gets a new grant only after the other pending requesters have each been served once.
- Counter: 16 bits, no wrap within a frame. A FRAME_CYC+GAP_CYC overflowing 16 bits is a parameter error and must be flagged by an elaboration-time check.
- Simultaneous requests in IDLE: exactly one ack per arbitration, never two.

Optional Feature:
- Macro: UART_ARB_FIXED_PRI_EN.
- Defined: fixed priority. The lowest-index set req always wins and rr_ptr is unused. Requester 0 can starve the others.
- Undefined (default): round-robin as described under Behaviour.

Test Plan:
All scenarios use CLK_FREQ=1000, BAUD=100, so BPS_CNT=10, FRAME_CYC=103, GAP_CYC=10.
1. Single request: req=4'b0001, data 8'hA5 -> ack[0] for 1 cycle; uart_data=A5; uart_en high 3 cycles starting 1 cycle after ack; busy high for 113 cycles; transmitter line shows 0,1,0,1,0,0,1,0,1,1.
2. All requesters held high, bytes 11/22/33/44 -> grant order 0,1,2,3,0; acks spaced 114 cycles; grant_id follows.
3. Same stimulus as 2 with UART_ARB_FIXED_PRI_EN defined -> only requester 0 is ever acked.
4. req[2] raised mid-SEND of requester 1 -> no ack until GAP ends; ack[2] on the first IDLE cycle after GAP.
5. rst pulsed at SEND cnt=50 -> uart_en=0, busy=0, state IDLE same cycle. After release, pending req is granted to requester rr_ptr+1 = requester 0.
6. req[3] pulsed 1 cycle during GAP then dropped -> no ack[3]; arbiter returns to IDLE with busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers; UART_ARB_FIXED_PRI_EN selects fixed priority.
// Latency: ack and grant 1 cycle after req is seen in IDLE; uart_en follows 1 cycle later for EN_HOLD cycles.
// Backpressure: requesters hold req/data until ack; no grant is issued until the frame and idle gap have elapsed.
module uart_tx_arbiter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BPS_CNT  = CLK_FREQ / BAUD,
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int EN_HOLD  = 3,
    parameter int GAP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 uart_en,
    output logic [7:0]           uart_data,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    localparam int          FRAME_CYC  = 10 * BPS_CNT + EN_HOLD;
    localparam int          GAP_CYC    = GAP_BITS * BPS_CNT;
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYC - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
    localparam logic [15:0] EN_LIMIT   = 16'(EN_HOLD);

    generate
        if (FRAME_CYC + GAP_CYC > 65535) begin : g_cnt_overflow
            $error("uart_tx_arbiter: FRAME_CYC + GAP_CYC does not fit the 16-bit counter");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_range
            $error("uart_tx_arbiter: NUM_REQ must be 2..8");
        end
        if (ID_W != $clog2(NUM_REQ)) begin : g_id_w_match
            $error("uart_tx_arbiter: ID_W must equal clog2(NUM_REQ)");
        end
        if (EN_HOLD < 3) begin : g_en_hold_min
            $error("uart_tx_arbiter: EN_HOLD must be at least 3");
        end
        if (BPS_CNT < 1) begin : g_bps_min
            $error("uart_tx_arbiter: BPS_CNT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 uart_en_q, uart_en_d;
    logic [7:0]           uart_data_q, uart_data_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [ID_W-1:0]      winner;
    logic [7:0]           win_byte;
    logic                 grant;

    assign grant = (state_q == IDLE) && (|req);

`ifdef UART_ARB_FIXED_PRI_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    // Rotate so bit j of req_rot is requester (rr_ptr+1+j) mod NUM_REQ; lowest j wins.
    assign req_dbl = {req, req};

    always_comb begin
        winner  = '0;
        req_rot = NUM_REQ'(req_dbl >> (int'(rr_ptr_q) + 1));
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                winner = ID_W'((int'(rr_ptr_q) + 1 + j) % NUM_REQ);
            end
        end
    end

    assign rr_ptr_d = grant ? winner : rr_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        uart_en_d   = 1'b0;
        uart_data_d = uart_data_q;
        grant_id_d  = grant_id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_d[i] = (winner == ID_W'(i));
                    end
                    uart_data_d = win_byte;
                    grant_id_d  = winner;
                    cnt_d       = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // Registered, so uart_en trails ack by one cycle and lasts EN_HOLD cycles.
                uart_en_d = (cnt_q < EN_LIMIT);
                if (cnt_q == FRAME_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYC > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ack_q       <= '0;
            uart_en_q   <= 1'b0;
            uart_data_q <= '0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            uart_en_q   <= uart_en_d;
            uart_data_q <= uart_data_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign ack       = ack_q;
    assign uart_en   = uart_en_q;
    assign uart_data = uart_data_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_id_q;

endmodule
